// File: rtl/flappy_game_ctrl.sv
// rtl/flappy_game_ctrl.sv - Flappy Bird game sequencing, bird physics, scroll gating and BCD score
module flappy_game_ctrl #(
    parameter int SCREEN_H    = 480,
    parameter int BIRD_H      = 16,
    parameter int START_Y     = 232,
    parameter int GRAV        = 1,
    parameter int FLAP_VEL    = 8,
    parameter int VMAX        = 12,
    parameter int DEAD_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       flap_btn,
    input  logic       start_btn,
    input  logic       frame_tick,
    input  logic       collide,
    input  logic       pipe_passed,
    output logic [8:0] bird_y,
    output logic       scroll_en,
    output logic       pipe_reset,
    output logic [7:0] score,
    output logic [1:0] game_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int CW = $clog2(DEAD_FRAMES + 1);
    localparam logic [8:0]        FLOOR_Y = 9'(SCREEN_H - BIRD_H);
    localparam logic [8:0]        START_V = 9'(START_Y);
    localparam logic signed [6:0] GRAV_V  = 7'(GRAV);
    localparam logic signed [6:0] VMAX_V  = 7'(VMAX);
    localparam logic signed [5:0] FLAP_V  = 6'(-FLAP_VEL);
    localparam logic [CW-1:0]     DEAD_LAST = CW'(DEAD_FRAMES - 1);

    state_t             state_q, state_d;
    logic [8:0]         bird_y_q, bird_y_d;
    logic signed [5:0]  vel_q, vel_d;
    logic               flap_pend_q, flap_pend_d;
    logic [7:0]         score_q, score_d;
    logic               pipe_reset_q, pipe_reset_d;
    logic [CW-1:0]      dead_cnt_q, dead_cnt_d;

    logic flap_s1_q, flap_s2_q, flap_prev_q;
    logic start_s1_q, start_s2_q, start_prev_q;
    logic flap_edge, start_edge;

    logic signed [6:0]  vel_inc;
    logic signed [5:0]  vel_fall, vel_phys;
    logic signed [10:0] y_sum;
    logic [8:0]         y_new;
    logic [7:0]         score_inc;
    logic               dying;

    // Button synchronizers and previous-value registers for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flap_s1_q    <= 1'b0;
            flap_s2_q    <= 1'b0;
            flap_prev_q  <= 1'b0;
            start_s1_q   <= 1'b0;
            start_s2_q   <= 1'b0;
            start_prev_q <= 1'b0;
        end else if (ena) begin
            flap_s1_q    <= flap_btn;
            flap_s2_q    <= flap_s1_q;
            flap_prev_q  <= flap_s2_q;
            start_s1_q   <= start_btn;
            start_s2_q   <= start_s1_q;
            start_prev_q <= start_s2_q;
        end
    end

    assign flap_edge  = flap_s2_q & ~flap_prev_q;
    assign start_edge = start_s2_q & ~start_prev_q;

    // Game state and physics registers, all frozen while the tile is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bird_y_q     <= START_V;
            vel_q        <= '0;
            flap_pend_q  <= 1'b0;
            score_q      <= 8'h00;
            pipe_reset_q <= 1'b0;
            dead_cnt_q   <= '0;
        end else if (ena) begin
            state_q      <= state_d;
            bird_y_q     <= bird_y_d;
            vel_q        <= vel_d;
            flap_pend_q  <= flap_pend_d;
            score_q      <= score_d;
            pipe_reset_q <= pipe_reset_d;
            dead_cnt_q   <= dead_cnt_d;
        end
    end

    // Per-frame physics: gravity with terminal velocity, flap override, clamp to screen
    always_comb begin
        vel_inc  = $signed({vel_q[5], vel_q}) + GRAV_V;
        vel_fall = (vel_inc > VMAX_V) ? VMAX_V[5:0] : vel_inc[5:0];
        vel_phys = (state_q == ST_PLAY && flap_pend_q) ? FLAP_V : vel_fall;
        y_sum    = $signed({2'b00, bird_y_q}) + $signed({{5{vel_phys[5]}}, vel_phys});
        if (y_sum[10]) begin
            y_new = 9'd0;
        end else if (y_sum > $signed({2'b00, FLOOR_Y})) begin
            y_new = FLOOR_Y;
        end else begin
            y_new = y_sum[8:0];
        end
    end

    // Saturating two-digit BCD increment
    always_comb begin
        score_inc = score_q;
        if (score_q != 8'h99) begin
            if (score_q[3:0] == 4'd9) begin
                score_inc = {score_q[7:4] + 4'd1, 4'd0};
            end else begin
                score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
            end
        end
    end

    // Next-state logic; a frame_tick in a transition cycle is handled under the old state
    always_comb begin
        state_d      = state_q;
        bird_y_d     = bird_y_q;
        vel_d        = vel_q;
        flap_pend_d  = flap_pend_q;
        score_d      = score_q;
        pipe_reset_d = 1'b0;
        dead_cnt_d   = dead_cnt_q;
        dying        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bird_y_d    = START_V;
                vel_d       = '0;
                flap_pend_d = 1'b0;
                if (start_edge) begin
                    state_d      = ST_PLAY;
                    pipe_reset_d = 1'b1;
                    score_d      = 8'h00;
                end
            end
            ST_PLAY: begin
                flap_pend_d = flap_pend_q | flap_edge;
                if (frame_tick) begin
                    flap_pend_d = flap_edge;
                    vel_d       = vel_phys;
                    bird_y_d    = y_new;
                    if (collide || y_new == FLOOR_Y) begin
                        dying       = 1'b1;
                        state_d     = ST_DEAD;
                        dead_cnt_d  = '0;
                        flap_pend_d = 1'b0;
                    end
                end
                if (pipe_passed && !dying) begin
                    score_d = score_inc;
                end
            end
            ST_DEAD: begin
                flap_pend_d = 1'b0;
                if (frame_tick) begin
                    vel_d    = vel_phys;
                    bird_y_d = y_new;
                    if (dead_cnt_q == DEAD_LAST) begin
                        state_d = ST_OVER;
                    end else begin
                        dead_cnt_d = dead_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                flap_pend_d = 1'b0;
                if (start_edge) begin
                    state_d  = ST_IDLE;
                    bird_y_d = START_V;
                    vel_d    = '0;
                end
            end
        endcase
    end

    assign bird_y     = bird_y_q;
    assign scroll_en  = (state_q == ST_PLAY);
    assign pipe_reset = pipe_reset_q;
    assign score      = score_q;
    assign game_state = state_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb/tb_flappy_game_ctrl.sv - directed self-checking bench for flappy_game_ctrl
module tb_flappy_game_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       flap_btn;
    logic       start_btn;
    logic       frame_tick;
    logic       collide;
    logic       pipe_passed;
    logic [8:0] bird_y;
    logic       scroll_en;
    logic       pipe_reset;
    logic [7:0] score;
    logic [1:0] game_state;

    int checks;
    int failures;

    flappy_game_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .flap_btn   (flap_btn),
        .start_btn  (start_btn),
        .frame_tick (frame_tick),
        .collide    (collide),
        .pipe_passed(pipe_passed),
        .bird_y     (bird_y),
        .scroll_en  (scroll_en),
        .pipe_reset (pipe_reset),
        .score      (score),
        .game_state (game_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        cyc(1);
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        cyc(3);
        start_btn = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(2);
        checks++;
        if (game_state !== 2'd0 || bird_y !== 9'd232 || score !== 8'h00 || scroll_en !== 1'b0 || pipe_reset !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: state=%0d y=%0d score=%h scroll=%b prst=%b", game_state, bird_y, score, scroll_en, pipe_reset);
        end
        rst_n = 1'b1;
        cyc(2);
        for (int i = 0; i < 100; i++) tick();
        checks++;
        if (game_state !== 2'd0 || bird_y !== 9'd232 || score !== 8'h00 || scroll_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_ticks: state=%0d y=%0d score=%h scroll=%b expected 0/232/00/0", game_state, bird_y, score, scroll_en);
        end
    endtask

    task automatic test_start();
        start_btn = 1'b1;
        cyc(2);
        checks++;
        if (game_state !== 2'd0) begin
            failures++;
            $display("FAIL start_latency: state=%0d expected 0 before third edge", game_state);
        end
        cyc(1);
        start_btn = 1'b0;
        checks++;
        if (game_state !== 2'd1 || pipe_reset !== 1'b1 || scroll_en !== 1'b1 || score !== 8'h00) begin
            failures++;
            $display("FAIL start_play: state=%0d prst=%b scroll=%b score=%h expected 1/1/1/00", game_state, pipe_reset, scroll_en, score);
        end
        cyc(1);
        checks++;
        if (pipe_reset !== 1'b0) begin
            failures++;
            $display("FAIL pipe_reset_width: pipe_reset=%b expected 0", pipe_reset);
        end
        cyc(4);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (bird_y !== 9'd247) begin
            failures++;
            $display("FAIL gravity: bird_y=%0d expected 247", bird_y);
        end
    endtask

    task automatic test_flap();
        flap_btn = 1'b1;
        cyc(3);
        tick();
        checks++;
        if (bird_y !== 9'd239) begin
            failures++;
            $display("FAIL flap_once: bird_y=%0d expected 239", bird_y);
        end
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (bird_y !== 9'd212) begin
            failures++;
            $display("FAIL flap_held: bird_y=%0d expected 212", bird_y);
        end
        flap_btn = 1'b0;
        cyc(4);
    endtask

    task automatic test_ena_freeze();
        ena = 1'b0;
        tick();
        pipe_passed = 1'b1;
        cyc(1);
        pipe_passed = 1'b0;
        ena = 1'b1;
        checks++;
        if (bird_y !== 9'd212 || score !== 8'h00) begin
            failures++;
            $display("FAIL ena_freeze: bird_y=%0d score=%h expected 212/00", bird_y, score);
        end
    endtask

    task automatic test_collide_same_cycle();
        for (int i = 0; i < 5; i++) begin
            pipe_passed = 1'b1;
            cyc(1);
            pipe_passed = 1'b0;
        end
        collide     = 1'b1;
        pipe_passed = 1'b1;
        frame_tick  = 1'b1;
        cyc(1);
        collide     = 1'b0;
        pipe_passed = 1'b0;
        frame_tick  = 1'b0;
        checks++;
        if (game_state !== 2'd2 || scroll_en !== 1'b0 || score !== 8'h05 || bird_y !== 9'd214) begin
            failures++;
            $display("FAIL collide_dead: state=%0d scroll=%b score=%h y=%0d expected 2/0/05/214", game_state, scroll_en, score, bird_y);
        end
    endtask

    task automatic test_dead_over();
        cyc(1);
        for (int i = 0; i < 59; i++) tick();
        checks++;
        if (game_state !== 2'd2 || bird_y !== 9'd464) begin
            failures++;
            $display("FAIL dead_fall: state=%0d y=%0d expected 2/464", game_state, bird_y);
        end
        tick();
        checks++;
        if (game_state !== 2'd3 || score !== 8'h05) begin
            failures++;
            $display("FAIL over: state=%0d score=%h expected 3/05", game_state, score);
        end
        press_start();
        cyc(4);
        checks++;
        if (game_state !== 2'd0 || bird_y !== 9'd232 || score !== 8'h05) begin
            failures++;
            $display("FAIL restart_idle: state=%0d y=%0d score=%h expected 0/232/05", game_state, bird_y, score);
        end
    endtask

    task automatic test_score();
        press_start();
        cyc(4);
        checks++;
        if (game_state !== 2'd1 || score !== 8'h00) begin
            failures++;
            $display("FAIL replay: state=%0d score=%h expected 1/00", game_state, score);
        end
        for (int i = 1; i <= 100; i++) begin
            pipe_passed = 1'b1;
            cyc(1);
            pipe_passed = 1'b0;
            if (i == 9) begin
                checks++;
                if (score !== 8'h09) begin
                    failures++;
                    $display("FAIL score_9: score=%h expected 09", score);
                end
            end
            if (i == 10) begin
                checks++;
                if (score !== 8'h10) begin
                    failures++;
                    $display("FAIL score_10: score=%h expected 10", score);
                end
            end
            if (i == 99) begin
                checks++;
                if (score !== 8'h99) begin
                    failures++;
                    $display("FAIL score_99: score=%h expected 99", score);
                end
            end
        end
        checks++;
        if (score !== 8'h99) begin
            failures++;
            $display("FAIL score_sat: score=%h expected 99", score);
        end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (game_state !== 2'd0 || bird_y !== 9'd232 || score !== 8'h00 || scroll_en !== 1'b0 || pipe_reset !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: state=%0d y=%0d score=%h scroll=%b prst=%b", game_state, bird_y, score, scroll_en, pipe_reset);
        end
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        checks++;
        if (pipe_reset !== 1'b0 || game_state !== 2'd0) begin
            failures++;
            $display("FAIL post_reset: prst=%b state=%0d expected 0/0", pipe_reset, game_state);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        ena         = 1'b1;
        flap_btn    = 1'b0;
        start_btn   = 1'b0;
        frame_tick  = 1'b0;
        collide     = 1'b0;
        pipe_passed = 1'b0;
        test_reset();
        test_start();
        test_flap();
        test_ena_freeze();
        test_collide_same_cycle();
        test_dead_over();
        test_score();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
